// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that lets N_REQ byte producers share one UART transmitter.
// Each grant issues exactly one byte on din/wr_en. The arbiter then waits for the
// UART to raise tx_busy and drop it again before it grants the next byte.
// If tx_busy never rises after a write, the frame is dropped and a sticky error is
// raised. A 16-bit counter tracks how many frames completed.

module uart_tx_arbiter #(
    parameter  int N_REQ        = 4,
    parameter  int BUSY_TIMEOUT = 64,
    localparam int GW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           din,
    output logic                 wr_en,
    input  logic                 tx_busy,
    output logic [GW-1:0]        grant_id,
    output logic                 active,
    output logic                 timeout_err,
    input  logic                 err_clr,
    output logic [15:0]          sent_count
);

    // Timer only has to reach BUSY_TIMEOUT-1, so clog2 bits are enough.
    localparam int              TW         = $clog2(BUSY_TIMEOUT);
    localparam logic [GW-1:0]   LAST_RST   = GW'(N_REQ - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     last_grant_nxt;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nxt;

    logic [7:0]        lane [N_REQ];
    logic              pick_found;
    logic [GW-1:0]     pick_idx;
    logic [7:0]        pick_data;

    logic              grant_fire;
    logic              timeout_fire;
    logic              frame_done;

    logic [N_REQ-1:0]  req_ready_nxt;
    logic [7:0]        din_nxt;
    logic              wr_en_nxt;
    logic [GW-1:0]     grant_id_nxt;
    logic              active_nxt;
    logic              timeout_err_nxt;
    logic [15:0]       sent_count_nxt;

    // Split the flat request bus into one byte lane per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign lane[g] = req_data[8*g +: 8];
    end

    // Round-robin pick: first valid requester after last_grant, wrapping mod N_REQ.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_grant) + k) % N_REQ;
            if (!pick_found && req_valid[GW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(cand);
            end
        end
        pick_data = lane[pick_idx];
    end

    // Events that drive the registered outputs; tx_busy high in IDLE blocks grants.
    always_comb begin
        grant_fire   = (state == IDLE) && pick_found && !tx_busy;
        timeout_fire = (state == WAIT_HI) && !tx_busy && (timer == TIMER_LAST);
        frame_done   = (state == WAIT_LO) && !tx_busy;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT_HI -> WAIT_LO cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_fire) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = WAIT_LO;
                end else if (timeout_fire) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_LO: begin
                if (frame_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Next values of all registered outputs, the grant history and the busy timer.
    always_comb begin
        din_nxt         = din;
        grant_id_nxt    = grant_id;
        last_grant_nxt  = last_grant;
        wr_en_nxt       = 1'b0;
        req_ready_nxt   = '0;
        timer_nxt       = timer;
        sent_count_nxt  = sent_count;
        timeout_err_nxt = timeout_err;
        active_nxt      = (state_nxt != IDLE);

        if (grant_fire) begin
            din_nxt        = pick_data;
            grant_id_nxt   = pick_idx;
            last_grant_nxt = pick_idx;
            wr_en_nxt      = 1'b1;
            req_ready_nxt  = N_REQ'(1) << pick_idx;
        end

        // The timer restarts on leaving ISSUE and counts while tx_busy stays low.
        if (state == ISSUE) begin
            timer_nxt = '0;
        end else if ((state == WAIT_HI) && !tx_busy && !timeout_fire) begin
            timer_nxt = timer + TW'(1);
        end

        if (frame_done) begin
            sent_count_nxt = sent_count + 16'd1;
        end

        // A timeout in the same cycle as err_clr keeps the error set.
        if (timeout_fire) begin
            timeout_err_nxt = 1'b1;
        end else if (err_clr) begin
            timeout_err_nxt = 1'b0;
        end
    end

    // Output and bookkeeping registers; reset puts priority back on requester 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            din         <= 8'd0;
            wr_en       <= 1'b0;
            req_ready   <= '0;
            grant_id    <= '0;
            last_grant  <= LAST_RST;
            active      <= 1'b0;
            timeout_err <= 1'b0;
            sent_count  <= 16'd0;
            timer       <= '0;
        end else begin
            din         <= din_nxt;
            wr_en       <= wr_en_nxt;
            req_ready   <= req_ready_nxt;
            grant_id    <= grant_id_nxt;
            last_grant  <= last_grant_nxt;
            active      <= active_nxt;
            timeout_err <= timeout_err_nxt;
            sent_count  <= sent_count_nxt;
            timer       <= timer_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed steps with a grant scoreboard and a
// simple UART busy model (automatic or manually driven tx_busy).

module tb_uart_tx_arbiter;

    localparam int N_REQ = 4;
    localparam int BT    = 16;
    localparam int GW    = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [8*N_REQ-1:0] req_data = '0;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         din;
    logic               wr_en;
    logic               tx_busy;
    logic [GW-1:0]      grant_id;
    logic               active;
    logic               timeout_err;
    logic               err_clr = 1'b0;
    logic [15:0]        sent_count;

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .din         (din),
        .wr_en       (wr_en),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .sent_count  (sent_count)
    );

    always #5 clk = ~clk;

    // UART busy model: rises busy_rise cycles after the wr_en cycle, stays high busy_len cycles.
    logic manual   = 1'b1;
    logic busy_man = 1'b0;
    logic busy_m   = 1'b0;
    int   busy_rise = 2;
    int   busy_len  = 10;
    int   rise_cnt  = 0;
    int   hold_cnt  = 0;
    int   overlap_cnt = 0;

    assign tx_busy = manual ? busy_man : busy_m;

    always @(posedge clk) begin
        if (reset) begin
            busy_m   <= 1'b0;
            rise_cnt <= 0;
            hold_cnt <= 0;
        end else if (wr_en) begin
            if (busy_rise <= 1) begin
                busy_m   <= 1'b1;
                hold_cnt <= busy_len;
            end else begin
                rise_cnt <= busy_rise - 1;
            end
        end else if (rise_cnt > 0) begin
            if (rise_cnt == 1) begin
                busy_m   <= 1'b1;
                hold_cnt <= busy_len;
            end
            rise_cnt <= rise_cnt - 1;
        end else if (hold_cnt > 0) begin
            if (hold_cnt == 1) begin
                busy_m <= 1'b0;
            end
            hold_cnt <= hold_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (!reset && wr_en && tx_busy) begin
            overlap_cnt <= overlap_cnt + 1;
        end
    end

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        err_clr   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Wait (bounded) for the wr_en cycle, then compare against the scoreboard head.
    task automatic expect_grant(input string tag, input int bound);
        exp_t       e;
        logic [3:0] oh;
        int         n;
        n = 0;
        while (wr_en !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        check({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
        if (wr_en === 1'b1 && sb.size() > 0) begin
            e  = sb.pop_front();
            oh = 4'b0001 << e.id;
            check({tag, "_din"}, 32'(din), 32'(e.data));
            check({tag, "_grant_id"}, 32'(grant_id), 32'(e.id));
            check({tag, "_req_ready"}, 32'(req_ready), 32'(oh));
        end
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (active !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(active), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov0;
        int id;

        // Reset state
        do_reset();
        check("rst_din", 32'(din), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_sent_count", 32'(sent_count), 32'd0);

        // 1: single request from requester 2
        manual    = 1'b0;
        busy_rise = 2;
        busy_len  = 10;
        req_data  = 32'h00A5_0000;
        req_valid = 4'b0100;
        push(2, 8'hA5);
        expect_grant("t1", 1);
        req_valid = '0;
        tick();
        check("t1_wr_en_pulse", 32'(wr_en), 32'd0);
        check("t1_ready_pulse", 32'(req_ready), 32'd0);
        wait_idle("t1", 40);
        check("t1_sent_count", 32'(sent_count), 32'd1);
        check("t1_din_hold", 32'(din), 32'hA5);
        check("t1_grant_hold", 32'(grant_id), 32'd2);

        // 2: fairness with all four requesters valid
        do_reset();
        manual    = 1'b0;
        busy_rise = 2;
        busy_len  = 3;
        ov0       = overlap_cnt;
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        push(0, 8'h10);
        push(1, 8'h11);
        push(2, 8'h12);
        push(3, 8'h13);
        push(0, 8'h20);
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            expect_grant("t2", 30);
            req_data[8*id +: 8] = 8'(8'h20 + id);
            if (k == 4) begin
                req_valid = '0;
            end
            tick();
            check("t2_ready_pulse", 32'(req_ready), 32'd0);
        end
        wait_idle("t2", 40);
        check("t2_sent_count", 32'(sent_count), 32'd5);
        check("t2_no_wr_while_busy", 32'(overlap_cnt), 32'(ov0));

        // 3: busy timeout, then normal grant
        do_reset();
        manual    = 1'b1;
        busy_man  = 1'b0;
        req_data  = 32'h0000_3C00;
        req_valid = 4'b0010;
        push(1, 8'h3C);
        expect_grant("t3", 1);
        req_valid = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        check("t3_no_early_timeout", 32'(timeout_err), 32'd0);
        check("t3_active_wait", 32'(active), 32'd1);
        tick();
        check("t3_timeout_err", 32'(timeout_err), 32'd1);
        check("t3_active_off", 32'(active), 32'd0);
        check("t3_sent_unchanged", 32'(sent_count), 32'd0);
        manual    = 1'b0;
        busy_rise = 2;
        busy_len  = 3;
        req_data  = 32'h7700_0000;
        req_valid = 4'b1000;
        push(3, 8'h77);
        expect_grant("t3b", 2);
        req_valid = '0;
        wait_idle("t3b", 40);
        check("t3b_sent_count", 32'(sent_count), 32'd1);
        check("t3b_err_sticky", 32'(timeout_err), 32'd1);

        // 4: reset while in WAIT_LO
        do_reset();
        manual    = 1'b0;
        busy_rise = 2;
        busy_len  = 10;
        req_data  = 32'h4400_0000;
        req_valid = 4'b1000;
        push(3, 8'h44);
        expect_grant("t4", 2);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("t4_grant_pre", 32'(grant_id), 32'd3);
        check("t4_active_pre", 32'(active), 32'd1);
        reset = 1'b1;
        tick();
        check("t4_rst_din", 32'(din), 32'd0);
        check("t4_rst_wr_en", 32'(wr_en), 32'd0);
        check("t4_rst_req_ready", 32'(req_ready), 32'd0);
        check("t4_rst_grant_id", 32'(grant_id), 32'd0);
        check("t4_rst_active", 32'(active), 32'd0);
        check("t4_rst_sent_count", 32'(sent_count), 32'd0);
        reset     = 1'b0;
        req_data  = 32'h0D0C_0B0A;
        req_valid = 4'b1111;
        push(0, 8'h0A);
        expect_grant("t4b", 2);
        req_valid = '0;
        wait_idle("t4b", 40);

        // 5: tx_busy high in IDLE blocks the grant
        do_reset();
        manual    = 1'b1;
        busy_man  = 1'b1;
        req_data  = 32'h0000_005A;
        req_valid = 4'b0001;
        push(0, 8'h5A);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_blocked", 32'({wr_en, req_ready}), 32'd0);
        end
        busy_man = 1'b0;
        expect_grant("t5", 1);
        req_valid = '0;
        tick();
        busy_man = 1'b1;
        tick();
        tick();
        busy_man = 1'b0;
        wait_idle("t5", 20);
        check("t5_sent_count", 32'(sent_count), 32'd1);

        // 6: err_clr behaviour and sent_count wrap
        do_reset();
        manual    = 1'b1;
        busy_man  = 1'b0;
        req_data  = 32'h0000_0061;
        req_valid = 4'b0001;
        push(0, 8'h61);
        expect_grant("t6a", 1);
        req_valid = '0;
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        check("t6_first_timeout", 32'(timeout_err), 32'd1);
        req_data  = 32'h0000_6200;
        req_valid = 4'b0010;
        push(1, 8'h62);
        expect_grant("t6b", 2);
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        err_clr = 1'b1;
        tick();
        check("t6_err_cleared", 32'(timeout_err), 32'd0);
        err_clr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
        end
        err_clr = 1'b1;
        tick();
        check("t6_timeout_wins", 32'(timeout_err), 32'd1);
        err_clr = 1'b0;
        tick();
        check("t6_err_held", 32'(timeout_err), 32'd1);

        manual    = 1'b0;
        busy_rise = 2;
        busy_len  = 3;
        force dut.sent_count = 16'hFFFF;
        tick();
        release dut.sent_count;
        tick();
        check("t6_preload", 32'(sent_count), 32'hFFFF);
        req_data  = 32'h0099_0000;
        req_valid = 4'b0100;
        push(2, 8'h99);
        expect_grant("t6c", 2);
        req_valid = '0;
        wait_idle("t6c", 40);
        check("t6_wrap", 32'(sent_count), 32'h0000);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
